// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - parametrised raster timing and test-pattern generator
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 4,
  parameter int CHK_LOG2 = 3,
  parameter int CNT_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [1:0]        mode,
  input  logic [3*CW-1:0]   solid_rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [CNT_W-1:0]  x,
  output logic [CNT_W-1:0]  y,
  output logic              line_start,
  output logic              frame_start,
  output logic [3*CW-1:0]   rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] BW_M1    = CNT_W'(H_ACTIVE / 8 - 1);

  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic [7:0]       fc;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] bar_cnt;
  logic [2:0]       bar_idx;

  logic             h_last;
  logic             v_last;
  logic             act;
  logic             at_origin;
  logic [1:0]       mode_eff;
  logic             chk;
  logic [CW-1:0]    r_c;
  logic [CW-1:0]    g_c;
  logic [CW-1:0]    b_c;

  assign h_last    = (hc == H_LAST);
  assign v_last    = (vc == V_LAST);
  assign act       = (hc < H_ACT) && (vc < V_ACT);
  assign at_origin = (hc == '0) && (vc == '0);
  // The frame's first pixel already uses the freshly sampled mode, so a frame is never split.
  assign mode_eff  = at_origin ? mode : mode_q;
  assign chk       = hc[CHK_LOG2] ^ vc[CHK_LOG2];

  // Raster counters, frame counter and per-frame mode capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      hc     <= '0;
      vc     <= '0;
      fc     <= '0;
      mode_q <= '0;
    end else if (pix_en) begin
      hc <= h_last ? '0 : hc + 1'b1;
      if (h_last) begin
        vc <= v_last ? '0 : vc + 1'b1;
        if (v_last) fc <= fc + 1'b1;
      end
      if (at_origin) mode_q <= mode;
    end
  end

  // Bar index follows hc without a divider; it saturates at the last bar and rewinds each line.
  always_ff @(posedge clk) begin
    if (rst || (pix_en && h_last)) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (pix_en && (hc < H_ACT) && (bar_idx != 3'd7)) begin
      if (bar_cnt == BW_M1) begin
        bar_cnt <= '0;
        bar_idx <= bar_idx + 1'b1;
      end else begin
        bar_cnt <= bar_cnt + 1'b1;
      end
    end
  end

  // Pattern colour for the current counter position.
  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    case (mode_eff)
      2'd0: begin
        // Bar order white..black maps to inverted index bits: R=~b1, G=~b2, B=~b0.
        r_c = {CW{~bar_idx[1]}};
        g_c = {CW{~bar_idx[2]}};
        b_c = {CW{~bar_idx[0]}};
      end
      2'd1: begin
        r_c = hc[CW-1:0];
        g_c = vc[CW-1:0];
        b_c = fc[CW-1:0];
      end
      2'd2: begin
        r_c = {CW{chk}};
        g_c = {CW{chk}};
        b_c = {CW{chk}};
      end
      default: {r_c, g_c, b_c} = solid_rgb;
    endcase
  end

  // Registered outputs reflect the pixel the counters point at before they advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      rgb         <= '0;
    end else if (pix_en) begin
      hsync       <= ((hc >= HS_START) && (hc < HS_END)) ? H_POL : ~H_POL;
      vsync       <= ((vc >= VS_START) && (vc < VS_END)) ? V_POL : ~V_POL;
      de          <= act;
      x           <= act ? hc : '0;
      y           <= act ? vc : '0;
      line_start  <= act && (hc == '0);
      frame_start <= at_origin;
      rgb         <= act ? {r_c, g_c, b_c} : '0;
    end
  end

endmodule
